// File: rtl/fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predict_unit
// Brief    : Fetch next-PC generator with 2-bit counters, BTB lookup/update and
//            in-order in-flight prediction FIFO. PREDICT_STATS_EN adds stats.
// Revision : 1.0
// ============================================================================
module fetch_predict_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_BITS = 4,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    output logic [31:0] imemaddr,
    output logic        pred_taken,
    output logic        fetch_stall,
    input  logic        retire_valid,
    input  logic        retire_branch,
    input  logic        retire_taken,
    input  logic [31:0] retire_target,
    output logic        flush,
    output logic        btb_wen,
    output logic [31:0] btb_wpc,
    output logic [31:0] btb_wtarget
`ifdef PREDICT_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_ENTRIES = 1 << IDX_BITS;
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [31:0]         r_pc;
    logic [1:0]          r_cnt [c_ENTRIES];
    logic [31:0]         r_q_pc  [DEPTH];
    logic [31:0]         r_q_tgt [DEPTH];
    logic [DEPTH-1:0]    r_q_pt;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_flush;
    logic                r_btb_wen;
    logic [31:0]         r_btb_wpc;
    logic [31:0]         r_btb_wtarget;

    logic [IDX_BITS-1:0] w_fetch_idx;
    logic [IDX_BITS-1:0] w_h_idx;
    logic                w_pred_taken;
    logic [31:0]         w_pred_tgt;
    logic                w_full;
    logic                w_retire;
    logic [31:0]         w_h_pc;
    logic [31:0]         w_h_tgt;
    logic                w_h_pt;
    logic                w_mispredict;
    logic                w_adv;
    logic                w_btb_upd;
    logic [31:0]         w_redirect;

    assign w_fetch_idx  = r_pc[IDX_BITS+1:2];
    assign w_pred_taken = btb_hit && r_cnt[w_fetch_idx][1];
    assign w_pred_tgt   = w_pred_taken ? btb_target : r_pc + 32'd4;
    assign w_full       = (r_count == c_FULL);

    assign w_retire = retire_valid && (r_count != '0);
    assign w_h_pc   = r_q_pc[r_rd_ptr];
    assign w_h_tgt  = r_q_tgt[r_rd_ptr];
    assign w_h_pt   = r_q_pt[r_rd_ptr];
    assign w_h_idx  = w_h_pc[IDX_BITS+1:2];

    // A non-branch that was predicted taken (index/BTB aliasing) must also redirect.
    assign w_mispredict = w_retire &&
        (retire_branch ? ((retire_taken != w_h_pt) || (retire_taken && (retire_target != w_h_tgt)))
                       : w_h_pt);
    assign w_adv      = ihit && !stall && !w_full && !w_mispredict;
    assign w_btb_upd  = w_retire && retire_branch && retire_taken;
    assign w_redirect = (retire_branch && retire_taken) ? retire_target : w_h_pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_pc          <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_flush       <= 1'b0;
            r_btb_wen     <= 1'b0;
            r_btb_wpc     <= '0;
            r_btb_wtarget <= '0;
        end else begin
            r_flush   <= w_mispredict;
            r_btb_wen <= w_btb_upd;
            if (w_btb_upd) begin
                r_btb_wpc     <= w_h_pc;
                r_btb_wtarget <= retire_target;
            end
            if (w_mispredict) begin
                r_pc     <= w_redirect;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_adv) begin
                    r_pc     <= w_pred_tgt;
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_retire) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                case ({w_adv, w_retire})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload needs no reset: occupancy is tracked solely by the pointers/count.
    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_q_pc[r_wr_ptr]  <= r_pc;
            r_q_tgt[r_wr_ptr] <= btb_target;
            r_q_pt[r_wr_ptr]  <= w_pred_taken;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_cnt[i] <= 2'b01;
            end
        end else if (w_retire && retire_branch) begin
            if (retire_taken) begin
                if (r_cnt[w_h_idx] != 2'b11) begin
                    r_cnt[w_h_idx] <= r_cnt[w_h_idx] + 2'd1;
                end
            end else if (r_cnt[w_h_idx] != 2'b00) begin
                r_cnt[w_h_idx] <= r_cnt[w_h_idx] - 2'd1;
            end
        end
    end

`ifdef PREDICT_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_retire && retire_branch) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    assign imemaddr    = r_pc;
    assign pred_taken  = w_pred_taken;
    assign fetch_stall = w_full;
    assign flush       = r_flush;
    assign btb_wen     = r_btb_wen;
    assign btb_wpc     = r_btb_wpc;
    assign btb_wtarget = r_btb_wtarget;

endmodule
`default_nettype wire
